// File: rtl/seven_seg_digit_driver.sv
// Drives anode, segment and decimal-point pins from the scanner's anode rotation.
// Adds ghost blanking on digit changes, leading-zero blanking, per-digit blink and frame-aligned loads.
module seven_seg_digit_driver #(
  parameter int BLANK_CYCLES = 4,
  parameter int BLINK_BITS   = 24
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  anode_in_i,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_i,
  input  logic        blank_lz_i,
  input  logic [3:0]  blink_en_i,
  input  logic        load_i,
  output logic        ready_o,
  output logic [3:0]  anode_o,
  output logic [6:0]  seg_o,
  output logic        dp_n_o
);

  localparam int CW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES);

  logic [3:0]            s1_q, anode_s_q, anode_q;
  logic [CW-1:0]         blank_cnt_q, blank_cnt_d;
  logic [BLINK_BITS-1:0] blink_cnt_q;
  logic [15:0]           sh_value_q, act_value_q;
  logic [3:0]            sh_dp_q, act_dp_q, sh_blink_q, act_blink_q;
  logic                  sh_lz_q, act_lz_q, pending_q;
  logic [3:0]            anode_d, anode_out_q;
  logic [6:0]            seg_d, seg_q;
  logic                  dp_n_d, dp_n_q;

  logic       change, commit, accept, valid;
  logic [1:0] dig_sel;
  logic [3:0] nib, zero_from;

  function automatic logic [6:0] seg_lut(input logic [3:0] n);
    case (n)
      4'h0: seg_lut = 7'h40;  4'h1: seg_lut = 7'h79;
      4'h2: seg_lut = 7'h24;  4'h3: seg_lut = 7'h30;
      4'h4: seg_lut = 7'h19;  4'h5: seg_lut = 7'h12;
      4'h6: seg_lut = 7'h02;  4'h7: seg_lut = 7'h78;
      4'h8: seg_lut = 7'h00;  4'h9: seg_lut = 7'h10;
      4'hA: seg_lut = 7'h08;  4'hB: seg_lut = 7'h03;
      4'hC: seg_lut = 7'h46;  4'hD: seg_lut = 7'h21;
      4'hE: seg_lut = 7'h06;  default: seg_lut = 7'h0E;
    endcase
  endfunction

  assign change  = (anode_s_q != anode_q);
  // Commit only on entry to digit 0 so a frame never mixes old and new data.
  assign commit  = change && (anode_s_q == 4'b1110) && pending_q;
  assign accept  = load_i && !pending_q;
  assign ready_o = !pending_q;

  assign zero_from[3] = (act_value_q[15:12] == 4'h0);
  assign zero_from[2] = zero_from[3] && (act_value_q[11:8] == 4'h0);
  assign zero_from[1] = zero_from[2] && (act_value_q[7:4] == 4'h0);
  assign zero_from[0] = 1'b0;

  always_comb begin
    valid   = 1'b1;
    dig_sel = 2'd0;
    case (anode_s_q)
      4'b1110: dig_sel = 2'd0;
      4'b1101: dig_sel = 2'd1;
      4'b1011: dig_sel = 2'd2;
      4'b0111: dig_sel = 2'd3;
      default: valid = 1'b0;
    endcase
  end

  assign nib = act_value_q[{dig_sel, 2'b00} +: 4];

  always_comb begin
    blank_cnt_d = blank_cnt_q;
    if (change)
      blank_cnt_d = BLANK_LOAD;
    else if (blank_cnt_q != '0)
      blank_cnt_d = blank_cnt_q - CW'(1);
  end

  always_comb begin
    anode_d = 4'hF;
    seg_d   = 7'h7F;
    dp_n_d  = 1'b1;
    if (valid && !change && (blank_cnt_q == '0) &&
        !(blink_cnt_q[BLINK_BITS-1] && act_blink_q[dig_sel])) begin
      anode_d = anode_s_q;
      seg_d   = (act_lz_q && zero_from[dig_sel]) ? 7'h7F : seg_lut(nib);
      dp_n_d  = ~act_dp_q[dig_sel];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q        <= 4'hF;
      anode_s_q   <= 4'hF;
      anode_q     <= 4'hF;
      blank_cnt_q <= '0;
      blink_cnt_q <= '0;
      anode_out_q <= 4'hF;
      seg_q       <= 7'h7F;
      dp_n_q      <= 1'b1;
    end else begin
      s1_q        <= anode_in_i;
      anode_s_q   <= s1_q;
      anode_q     <= anode_s_q;
      blank_cnt_q <= blank_cnt_d;
      blink_cnt_q <= blink_cnt_q + BLINK_BITS'(1);
      anode_out_q <= anode_d;
      seg_q       <= seg_d;
      dp_n_q      <= dp_n_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_value_q  <= '0;
      sh_dp_q     <= '0;
      sh_lz_q     <= 1'b0;
      sh_blink_q  <= '0;
      act_value_q <= '0;
      act_dp_q    <= '0;
      act_lz_q    <= 1'b0;
      act_blink_q <= '0;
      pending_q   <= 1'b0;
    end else if (commit) begin
      act_value_q <= sh_value_q;
      act_dp_q    <= sh_dp_q;
      act_lz_q    <= sh_lz_q;
      act_blink_q <= sh_blink_q;
      pending_q   <= 1'b0;
    end else if (accept) begin
      sh_value_q  <= value_i;
      sh_dp_q     <= dp_i;
      sh_lz_q     <= blank_lz_i;
      sh_blink_q  <= blink_en_i;
      pending_q   <= 1'b1;
    end
  end

  assign anode_o = anode_out_q;
  assign seg_o   = seg_q;
  assign dp_n_o  = dp_n_q;

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// Self-checking bench for seven_seg_digit_driver: directed scenarios plus randomized frames
// checked against a digit-level reference model.
module tb_seven_seg_digit_driver;
  localparam int BC = 4;
  localparam int BB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  anode_i = 4'hF;
  logic [15:0] value_i = '0;
  logic [3:0]  dp_i = '0;
  logic        lz_i = 1'b0;
  logic [3:0]  blink_i = '0;
  logic        load_i = 1'b0;
  logic        ready_o, dp_n_o;
  logic [3:0]  anode_o;
  logic [6:0]  seg_o;

  int n_checks = 0;
  int n_fail = 0;
  int cyc;

  logic [3:0] p_an, r_an;
  logic [6:0] p_sg, r_sg;
  logic       r_dpn;
  int         r_dark;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seven_seg_digit_driver #(.BLANK_CYCLES(BC), .BLINK_BITS(BB)) dut (
    .clk_i(clk), .rst_i(rst), .anode_in_i(anode_i), .value_i(value_i), .dp_i(dp_i),
    .blank_lz_i(lz_i), .blink_en_i(blink_i), .load_i(load_i), .ready_o(ready_o),
    .anode_o(anode_o), .seg_o(seg_o), .dp_n_o(dp_n_o));

  always #5 clk = ~clk;

  // Cycles since reset release; tracks the free-running blink phase.
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0; else cyc <= cyc + 1;

  function automatic logic [6:0] m_seg(input logic [15:0] v, input logic lz, input int k);
    logic [15:0] up;
    up = v >> (4 * k);
    if (lz && k > 0 && up == 16'h0) return 7'h7F;
    return seg_tbl[up[3:0]];
  endfunction

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz, input logic [3:0] bl);
    value_i = v; dp_i = d; lz_i = lz; blink_i = bl; load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
  endtask

  task automatic do_change(input logic [3:0] a);
    anode_i = a;
    @(negedge clk);
    @(negedge clk);
    p_an = anode_o; p_sg = seg_o;
    r_dark = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (anode_o == 4'hF && seg_o == 7'h7F && dp_n_o == 1'b1) r_dark++;
      else break;
    end
    r_an = anode_o; r_sg = seg_o; r_dpn = dp_n_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      anode_i = 4'($urandom_range(0, 15));
      @(negedge clk);
      n_checks++; if ({anode_o, seg_o, dp_n_o, ready_o} !== {4'hF, 7'h7F, 1'b1, 1'b1}) begin
        n_fail++; $display("FAIL reset_dark got %h/%h/%b/%b want f/7f/1/1", anode_o, seg_o, dp_n_o, ready_o); end
    end
    anode_i = 4'hF;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if ({anode_o, seg_o, dp_n_o, ready_o} !== {4'hF, 7'h7F, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL idle_dark got %h/%h/%b/%b want f/7f/1/1", anode_o, seg_o, dp_n_o, ready_o); end
  endtask

  task automatic test_display();
    do_load(16'h12AF, 4'b0100, 1'b0, 4'b0000);
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL disp_ready_low got %b want 0", ready_o); end
    do_change(4'b1110);
    n_checks++; if (r_dark !== BC + 1) begin n_fail++; $display("FAIL disp_d0_dark got %0d want %0d", r_dark, BC + 1); end
    n_checks++; if ({r_an, r_sg, r_dpn} !== {4'b1110, 7'h0E, 1'b1}) begin
      n_fail++; $display("FAIL disp_d0 got %b/%h/%b want 1110/0e/1", r_an, r_sg, r_dpn); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL disp_ready_high got %b want 1", ready_o); end
    do_change(4'b1101);
    n_checks++; if ({p_an, p_sg} !== {4'b1110, 7'h0E}) begin
      n_fail++; $display("FAIL disp_old_pair got %b/%h want 1110/0e", p_an, p_sg); end
    n_checks++; if (r_dark !== BC + 1) begin n_fail++; $display("FAIL disp_d1_dark got %0d want %0d", r_dark, BC + 1); end
    n_checks++; if ({r_an, r_sg, r_dpn} !== {4'b1101, 7'h08, 1'b1}) begin
      n_fail++; $display("FAIL disp_d1 got %b/%h/%b want 1101/08/1", r_an, r_sg, r_dpn); end
    do_change(4'b1011);
    n_checks++; if (r_dark !== BC + 1) begin n_fail++; $display("FAIL disp_d2_dark got %0d want %0d", r_dark, BC + 1); end
    n_checks++; if ({r_an, r_sg, r_dpn} !== {4'b1011, 7'h24, 1'b0}) begin
      n_fail++; $display("FAIL disp_d2 got %b/%h/%b want 1011/24/0", r_an, r_sg, r_dpn); end
    do_change(4'b0111);
    n_checks++; if ({r_an, r_sg, r_dpn} !== {4'b0111, 7'h79, 1'b1}) begin
      n_fail++; $display("FAIL disp_d3 got %b/%h/%b want 0111/79/1", r_an, r_sg, r_dpn); end
  endtask

  task automatic test_lz();
    do_load(16'h0070, 4'b0000, 1'b1, 4'b0000);
    do_change(4'b1110);
    n_checks++; if ({r_an, r_sg} !== {4'b1110, 7'h40}) begin n_fail++; $display("FAIL lz_d0 got %b/%h want 1110/40", r_an, r_sg); end
    do_change(4'b1101);
    n_checks++; if ({r_an, r_sg} !== {4'b1101, 7'h78}) begin n_fail++; $display("FAIL lz_d1 got %b/%h want 1101/78", r_an, r_sg); end
    do_change(4'b1011);
    n_checks++; if ({r_an, r_sg} !== {4'b1011, 7'h7F}) begin n_fail++; $display("FAIL lz_d2 got %b/%h want 1011/7f", r_an, r_sg); end
    do_change(4'b0111);
    n_checks++; if ({r_an, r_sg} !== {4'b0111, 7'h7F}) begin n_fail++; $display("FAIL lz_d3 got %b/%h want 0111/7f", r_an, r_sg); end
    do_load(16'h0070, 4'b0000, 1'b0, 4'b0000);
    do_change(4'b1110);
    do_change(4'b0111);
    n_checks++; if ({r_an, r_sg} !== {4'b0111, 7'h40}) begin n_fail++; $display("FAIL nolz_d3 got %b/%h want 0111/40", r_an, r_sg); end
  endtask

  task automatic test_handshake();
    do_load(16'h1111, 4'b0000, 1'b0, 4'b0000);
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL hs_ready_low got %b want 0", ready_o); end
    do_load(16'h2222, 4'b0000, 1'b0, 4'b0000);
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL hs_ready_still_low got %b want 0", ready_o); end
    do_change(4'b1101);
    n_checks++; if (r_sg !== 7'h78) begin n_fail++; $display("FAIL hs_old_d1 got %h want 78", r_sg); end
    do_change(4'b1011);
    n_checks++; if (r_sg !== 7'h40) begin n_fail++; $display("FAIL hs_old_d2 got %h want 40", r_sg); end
    do_change(4'b1110);
    n_checks++; if ({ready_o, r_sg} !== {1'b1, 7'h79}) begin
      n_fail++; $display("FAIL hs_commit got %b/%h want 1/79", ready_o, r_sg); end
    for (int k = 1; k < 4; k++) begin
      do_change(~(4'b0001 << k));
      n_checks++; if (r_sg !== 7'h79) begin n_fail++; $display("FAIL hs_new_d%0d got %h want 79", k, r_sg); end
    end
  endtask

  task automatic test_blink();
    logic exp_dark;
    do_load(16'h0000, 4'b0000, 1'b0, 4'b0001);
    do_change(4'b1110);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      exp_dark = (((cyc - 1) >> (BB - 1)) & 1) != 0;
      n_checks++; if ({anode_o, seg_o} !== (exp_dark ? {4'hF, 7'h7F} : {4'b1110, 7'h40})) begin
        n_fail++; $display("FAIL blink_c%0d got %b/%h want dark=%b", i, anode_o, seg_o, exp_dark); end
    end
  endtask

  task automatic test_reset_mid_blank();
    do_load(16'h5555, 4'b0000, 1'b0, 4'b0000);
    do_change(4'b1101);
    do_change(4'b1110);
    n_checks++; if (r_sg !== 7'h12) begin n_fail++; $display("FAIL rmb_commit got %h want 12", r_sg); end
    anode_i = 4'b1101;
    repeat (4) @(negedge clk);
    do_load(16'h3333, 4'b0000, 1'b0, 4'b0000);
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL rmb_pending got %b want 0", ready_o); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({anode_o, seg_o, dp_n_o, ready_o} !== {4'hF, 7'h7F, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL rmb_async got %h/%h/%b/%b want f/7f/1/1", anode_o, seg_o, dp_n_o, ready_o); end
    anode_i = 4'b1110;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_change(4'b1110);
    n_checks++; if (r_dark !== BC + 1) begin n_fail++; $display("FAIL rmb_dark got %0d want %0d", r_dark, BC + 1); end
    n_checks++; if ({r_an, r_sg, ready_o} !== {4'b1110, 7'h40, 1'b1}) begin
      n_fail++; $display("FAIL rmb_after got %b/%h/%b want 1110/40/1", r_an, r_sg, ready_o); end
  endtask

  task automatic test_random();
    logic [15:0] v;
    logic [3:0]  d;
    logic        lz;
    do_change(4'b0111);
    for (int it = 0; it < 8; it++) begin
      v = 16'($urandom);
      if (it % 3 == 0) v = v >> (4 * $urandom_range(1, 3));
      d = 4'($urandom);
      lz = 1'($urandom);
      do_load(v, d, lz, 4'b0000);
      n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_ready got %b want 0", it, ready_o); end
      for (int k = 0; k < 4; k++) begin
        do_change(~(4'b0001 << k));
        n_checks++; if (r_dark !== BC + 1) begin
          n_fail++; $display("FAIL rnd%0d_d%0d_dark got %0d want %0d", it, k, r_dark, BC + 1); end
        n_checks++; if ({r_an, r_sg, r_dpn} !== {~(4'b0001 << k), m_seg(v, lz, k), ~d[k]}) begin
          n_fail++; $display("FAIL rnd%0d_d%0d v=%h lz=%b got %b/%h/%b want %b/%h/%b", it, k, v, lz,
                             r_an, r_sg, r_dpn, ~(4'b0001 << k), m_seg(v, lz, k), ~d[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_display();
    test_lz();
    test_handshake();
    test_blink();
    test_reset_mid_blank();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
